// File: rtl/tcu_ctrl_mem_read_response.sv
// Consumes NoC read-response packets (header + data beats), writes the payload
// to local memory with byte enables and reports completion/size/error per packet.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | waiting for a header beat; non-header beats are discarded
// S_DATA   | writing payload beats to local memory
// S_DRAIN  | consuming beats until last (error, overflow or unexpected packet)
// S_REPORT | one-cycle completion pulse towards the request FSM
module tcu_ctrl_mem_read_response #(
   parameter int unsigned      DATA_W        = 64,
   parameter int unsigned      ERR_W         = 5,
   parameter logic [ERR_W-1:0] ERR_NONE      = '0,
   parameter logic [ERR_W-1:0] ERR_UNALIGNED = ERR_W'(5'h11),
   localparam int unsigned     DATA_B        = DATA_W / 8
) (
   input  logic              clk_i,
   input  logic              reset_n_i,
   input  logic              rsp_valid_i,
   output logic              rsp_ready_o,
   input  logic              rsp_first_i,
   input  logic              rsp_last_i,
   input  logic [ERR_W-1:0]  rsp_error_i,
   input  logic [DATA_W-1:0] rsp_data_i,
   input  logic              read_wait_i,
   output logic              mem_en_o,
   output logic [DATA_B-1:0] mem_wben_o,
   output logic [31:0]       mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_stall_i,
   output logic              noc_rsp_recv_o,
   output logic [ERR_W-1:0]  noc_rsp_error_o,
   output logic [31:0]       noc_rsp_size_o,
   output logic              drop_o
);

   localparam int unsigned       LOG_B      = $clog2(DATA_B);
   localparam logic [31:0]       BEAT_BYTES = 32'(DATA_B);
   localparam logic [DATA_B-1:0] WBEN_ALL   = '1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_DRAIN,
      S_REPORT
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      size_q, size_d;
   logic [31:0]      written_q, written_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic             unexp_q, unexp_d;
   logic             drop_q, drop_d;

   logic [31:0] remaining;
   logic [31:0] beat_bytes;
   logic [31:0] hdr_addr;
   logic [31:0] hdr_size;

   assign remaining   = size_q - written_q;
   assign beat_bytes  = (remaining >= BEAT_BYTES) ? BEAT_BYTES : remaining;
   assign hdr_addr    = rsp_data_i[31:0];
   assign hdr_size    = rsp_data_i[63:32];
   assign mem_wdata_o = rsp_data_i;
   assign drop_o      = drop_q;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      size_d    = size_q;
      written_d = written_q;
      err_d     = err_q;
      unexp_d   = unexp_q;
      drop_d    = 1'b0;

      rsp_ready_o     = 1'b0;
      mem_en_o        = 1'b0;
      mem_wben_o      = '0;
      mem_addr_o      = '0;
      noc_rsp_recv_o  = 1'b0;
      noc_rsp_error_o = ERR_NONE;
      noc_rsp_size_o  = '0;

      case (state_q)
         S_IDLE: begin
            rsp_ready_o = 1'b1;
            if (rsp_valid_i && rsp_first_i) begin
               addr_d    = hdr_addr;
               size_d    = hdr_size;
               written_d = '0;
               err_d     = ERR_NONE;
               unexp_d   = 1'b0;
               if (!read_wait_i) begin
                  unexp_d = 1'b1;
                  if (rsp_last_i) begin
                     state_d = S_IDLE;
                     drop_d  = 1'b1;
                  end else begin
                     state_d = S_DRAIN;
                  end
               end else if (rsp_error_i != ERR_NONE) begin
                  err_d   = rsp_error_i;
                  state_d = rsp_last_i ? S_REPORT : S_DRAIN;
               end else if (hdr_addr[LOG_B-1:0] != '0) begin
                  err_d   = ERR_UNALIGNED;
                  state_d = rsp_last_i ? S_REPORT : S_DRAIN;
               end else if ((hdr_size == '0) || rsp_last_i) begin
                  state_d = S_REPORT;
               end else begin
                  state_d = S_DATA;
               end
            end
         end

         S_DATA: begin
            rsp_ready_o = !mem_stall_i;
            mem_en_o    = rsp_valid_i;
            mem_addr_o  = addr_q + written_q;
            mem_wben_o  = (remaining >= BEAT_BYTES) ? WBEN_ALL
                                                    : ~(WBEN_ALL << remaining[LOG_B-1:0]);
            if (rsp_valid_i && !mem_stall_i) begin
               written_d = written_q + beat_bytes;
               // an overlong packet still owes its report once the tail is drained
               if (rsp_last_i) begin
                  state_d = S_REPORT;
               end else if (remaining == beat_bytes) begin
                  state_d = S_DRAIN;
               end
            end
         end

         S_DRAIN: begin
            rsp_ready_o = 1'b1;
            if (rsp_valid_i && rsp_last_i) begin
               if (unexp_q) begin
                  state_d = S_IDLE;
                  drop_d  = 1'b1;
               end else begin
                  state_d = S_REPORT;
               end
            end
         end

         S_REPORT: begin
            noc_rsp_recv_o  = 1'b1;
            noc_rsp_error_o = err_q;
            noc_rsp_size_o  = written_q;
            state_d         = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         size_q    <= '0;
         written_q <= '0;
         err_q     <= ERR_NONE;
         unexp_q   <= 1'b0;
         drop_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         size_q    <= size_d;
         written_q <= written_d;
         err_q     <= err_d;
         unexp_q   <= unexp_d;
         drop_q    <= drop_d;
      end
   end

endmodule

// File: tb/tb_tcu_ctrl_mem_read_response.sv
// Directed and randomized packet stimulus for tcu_ctrl_mem_read_response,
// checked against a packet-level model of the expected writes and reports.
module tb_tcu_ctrl_mem_read_response;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_first;
   logic        rsp_last;
   logic [4:0]  rsp_error;
   logic [63:0] rsp_data;
   logic        read_wait;
   logic        mem_en;
   logic [7:0]  mem_wben;
   logic [31:0] mem_addr;
   logic [63:0] mem_wdata;
   logic        mem_stall;
   logic        rsp_recv;
   logic [4:0]  rsp_err_out;
   logic [31:0] rsp_size;
   logic        drop;

   int total = 0;
   int bad   = 0;
   int nwr_obs = 0;

   always #5 clk_sys = ~clk_sys;

   tcu_ctrl_mem_read_response dut (
      .clk_i           (clk_sys),
      .reset_n_i       (reset_n),
      .rsp_valid_i     (rsp_valid),
      .rsp_ready_o     (rsp_ready),
      .rsp_first_i     (rsp_first),
      .rsp_last_i      (rsp_last),
      .rsp_error_i     (rsp_error),
      .rsp_data_i      (rsp_data),
      .read_wait_i     (read_wait),
      .mem_en_o        (mem_en),
      .mem_wben_o      (mem_wben),
      .mem_addr_o      (mem_addr),
      .mem_wdata_o     (mem_wdata),
      .mem_stall_i     (mem_stall),
      .noc_rsp_recv_o  (rsp_recv),
      .noc_rsp_error_o (rsp_err_out),
      .noc_rsp_size_o  (rsp_size),
      .drop_o          (drop)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_ready"}, 64'(rsp_ready), 64'd1);
      chk({tag, "_mem_en"}, 64'(mem_en), 64'd0);
      chk({tag, "_wben"}, 64'(mem_wben), 64'd0);
      chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
      chk({tag, "_recv"}, 64'(rsp_recv), 64'd0);
      chk({tag, "_err"}, 64'(rsp_err_out), 64'd0);
      chk({tag, "_size"}, 64'(rsp_size), 64'd0);
      chk({tag, "_drop"}, 64'(drop), 64'd0);
   endtask

   // Presents one beat until accepted; w says whether the model expects it written.
   task automatic drive_beat(input bit first, input bit last, input logic [4:0] err,
                             input logic [63:0] data, input bit rw, input bit w,
                             input logic [31:0] ea, input logic [7:0] ewb,
                             input int stall_n, input int pct);
      bit acc;
      int tries;
      acc   = 1'b0;
      tries = 0;
      rsp_valid = 1'b1;
      rsp_first = first;
      rsp_last  = last;
      rsp_error = err;
      rsp_data  = data;
      read_wait = rw;
      while (!acc && tries < 12) begin
         mem_stall = (tries < stall_n) ||
                     ((tries < stall_n + 4) && ($urandom_range(99) < 32'(pct)));
         #1;
         chk("ready", 64'(rsp_ready), 64'(w ? !mem_stall : 1'b1));
         chk("mem_en", 64'(mem_en), 64'(w));
         if (w) begin
            chk("mem_addr", 64'(mem_addr), 64'(ea));
            chk("mem_wben", 64'(mem_wben), 64'(ewb));
            chk("mem_wdata", mem_wdata, data);
         end
         chk("recv_mid", 64'(rsp_recv), 64'd0);
         chk("drop_mid", 64'(drop), 64'd0);
         if (mem_en && !mem_stall) nwr_obs++;
         acc = rsp_ready;
         tries++;
         @(negedge clk_sys);
      end
      chk("accept", 64'(acc), 64'd1);
      rsp_valid = 1'b0;
      mem_stall = 1'b0;
   endtask

   task automatic gap_cycle();
      rsp_valid = 1'b0;
      mem_stall = 1'b0;
      #1;
      chk("gap_ready", 64'(rsp_ready), 64'd1);
      chk("gap_mem_en", 64'(mem_en), 64'd0);
      chk("gap_recv", 64'(rsp_recv), 64'd0);
      @(negedge clk_sys);
   endtask

   // Model: the packet's writes, report and drop follow from its header fields.
   task automatic send_pkt(input logic [31:0] addr, input logic [31:0] size, input int nbeats,
                           input bit rw, input logic [4:0] err,
                           input int stall_beat, input int stall_n, input int pct);
      bit          do_write, exp_recv, exp_drop, w;
      logic [4:0]  exp_err;
      longint      exp_sz, off;
      int          exp_nwr;
      logic [7:0]  wb;
      logic [63:0] d;
      do_write = 1'b0; exp_recv = 1'b1; exp_drop = 1'b0;
      exp_err = 5'h0; exp_sz = 0; exp_nwr = 0;
      if (!rw) begin
         exp_recv = 1'b0;
         exp_drop = 1'b1;
      end else if (err != 5'h0) begin
         exp_err = err;
      end else if (addr[2:0] != 3'd0) begin
         exp_err = 5'h11;
      end else if (size != 0 && nbeats != 0) begin
         do_write = 1'b1;
         exp_sz = (longint'(size) < longint'(nbeats) * 8) ? longint'(size) : longint'(nbeats) * 8;
      end
      nwr_obs = 0;
      drive_beat(1'b1, nbeats == 0, err, {size, addr}, rw, 1'b0, 32'd0, 8'd0, 0, pct);
      if (nbeats > 0 && $urandom_range(3) == 0) gap_cycle();
      for (int i = 0; i < nbeats; i++) begin
         off = longint'(i) * 8;
         w   = do_write && (off < longint'(size));
         for (int b = 0; b < 8; b++) wb[b] = (off + b < longint'(size));
         if (w) exp_nwr++;
         d = {$urandom, $urandom};
         drive_beat(1'b0, i == nbeats - 1, 5'($urandom), d, 1'($urandom), w,
                    addr + 32'(off), wb, (i == stall_beat) ? stall_n : 0, pct);
         if (i < nbeats - 1 && $urandom_range(3) == 0) gap_cycle();
      end
      #1;
      chk("recv", 64'(rsp_recv), 64'(exp_recv));
      chk("rsp_size", 64'(rsp_size), exp_recv ? 64'(exp_sz) : 64'd0);
      chk("rsp_err", 64'(rsp_err_out), exp_recv ? 64'(exp_err) : 64'd0);
      chk("drop", 64'(drop), 64'(exp_drop));
      chk("post_ready", 64'(rsp_ready), 64'(!exp_recv));
      chk("post_mem_en", 64'(mem_en), 64'd0);
      chk("nwrites", 64'(nwr_obs), 64'(exp_nwr));
      @(negedge clk_sys);
   endtask

   initial begin
      logic [31:0] a, s;
      logic [4:0]  e;
      bit          rw;
      int          nb;

      reset_n = 1'b0; rsp_valid = 1'b0; rsp_first = 1'b0; rsp_last = 1'b0;
      rsp_error = 5'h0; rsp_data = '0; read_wait = 1'b0; mem_stall = 1'b0;
      repeat (2) @(negedge clk_sys);
      #1;
      check_reset_vals("rst");
      reset_n = 1'b1;
      @(negedge clk_sys);

      send_pkt(32'h1000, 32'd20, 3, 1'b1, 5'h0, -1, 0, 0);
      send_pkt(32'h1000, 32'd20, 3, 1'b1, 5'h0, 1, 3, 0);
      send_pkt(32'h3000, 32'd16, 2, 1'b1, 5'h3, -1, 0, 0);
      send_pkt(32'h1004, 32'd16, 2, 1'b1, 5'h0, -1, 0, 0);
      send_pkt(32'h1004, 32'd16, 0, 1'b1, 5'h0, -1, 0, 0);
      send_pkt(32'h4000, 32'd16, 2, 1'b0, 5'h0, -1, 0, 0);
      send_pkt(32'h4000, 32'd16, 2, 1'b1, 5'h0, -1, 0, 0);
      send_pkt(32'h5000, 32'd16, 0, 1'b0, 5'h0, -1, 0, 0);
      send_pkt(32'h6000, 32'd8, 3, 1'b1, 5'h0, -1, 0, 0);
      send_pkt(32'h7000, 32'd0, 0, 1'b1, 5'h0, -1, 0, 0);
      send_pkt(32'h7000, 32'd12, 0, 1'b1, 5'h0, -1, 0, 0);
      send_pkt(32'h8000, 32'd40, 2, 1'b1, 5'h0, -1, 0, 0);
      send_pkt(32'hFFFF_FFF8, 32'd16, 2, 1'b1, 5'h0, -1, 0, 0);

      // reset in the middle of a data phase
      nwr_obs = 0;
      drive_beat(1'b1, 1'b0, 5'h0, {32'd24, 32'h2000}, 1'b1, 1'b0, 32'd0, 8'd0, 0, 0);
      drive_beat(1'b0, 1'b0, 5'h0, 64'h1122_3344_5566_7788, 1'b1, 1'b1, 32'h2000, 8'hFF, 0, 0);
      reset_n = 1'b0;
      @(negedge clk_sys);
      #1;
      check_reset_vals("mid_rst");
      reset_n = 1'b1;
      @(negedge clk_sys);
      drive_beat(1'b0, 1'b0, 5'h0, 64'hAAAA, 1'b1, 1'b0, 32'd0, 8'd0, 0, 30);
      drive_beat(1'b0, 1'b1, 5'h0, 64'hBBBB, 1'b1, 1'b0, 32'd0, 8'd0, 0, 30);
      chk("rst_nwrites", 64'(nwr_obs), 64'd1);
      gap_cycle();
      send_pkt(32'h2000, 32'd24, 3, 1'b1, 5'h0, -1, 0, 30);

      for (int k = 0; k < 60; k++) begin
         a  = $urandom & 32'hFFFF_FFF8;
         if ($urandom_range(5) == 0) a[2:0] = 3'($urandom_range(7, 1));
         s  = 32'($urandom_range(40, 1));
         nb = $urandom_range(6);
         e  = ($urandom_range(5) == 0) ? 5'($urandom_range(31, 1)) : 5'h0;
         rw = ($urandom_range(5) != 0);
         send_pkt(a, s, nb, rw, e, -1, 0, 30);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tcu_ctrl_mem_read_response.md
# tcu_ctrl_mem_read_response

Consumer of NoC read-response packets for the TCU memory-access-request path. It accepts a header beat plus data beats, writes the payload into local memory with byte enables, and reports per-packet completion, byte count and error back to the request FSM. That FSM accumulates sizes until the requested length is reached. Packets that arrive while no read is outstanding are consumed and discarded.

## Interface

Parameters
- `DATA_W`, 64: data beat width in bits; `DATA_B = DATA_W/8` bytes per beat (power of two ≥ 8).
- `ERR_W`, 5: error code width.
- `ERR_NONE`, 5'h0: "no error" code.
- `ERR_UNALIGNED`, 5'h11: code reported when the header local address is not `DATA_B`-aligned.

Ports
- `clk_i`  in  1  clock.
- `reset_n_i`  in  1  reset, synchronous, active-low.
- `rsp_valid_i`  in  1  response beat valid.
- `rsp_ready_o`  out  1  beat accepted when `valid && ready`.
- `rsp_first_i`  in  1  beat is header. Header fields: `data[31:0]` = local addr, `data[63:32]` = payload bytes.
- `rsp_last_i`  in  1  final beat of the packet (may coincide with the header).
- `rsp_error_i`  in  ERR_W  sender error; sampled on the header beat only.
- `rsp_data_i`  in  DATA_W  header or payload.
- `read_wait_i`  in  1  request FSM is waiting for a response; sampled on the header beat.
- `mem_en_o`  out  1  local memory write strobe.
- `mem_wben_o`  out  DATA_B  byte enables.
- `mem_addr_o`  out  32  write byte address, `DATA_B`-aligned.
- `mem_wdata_o`  out  DATA_W  write data (`rsp_data_i` passed through).
- `mem_stall_i`  in  1  memory cannot take the write this cycle.
- `noc_rsp_recv_o`  out  1  one-cycle pulse: packet done.
- `noc_rsp_error_o`  out  ERR_W  valid with `recv`; `ERR_NONE` otherwise.
- `noc_rsp_size_o`  out  32  bytes written for this packet; valid with `recv`, otherwise 0.
- `drop_o`  out  1  one-cycle pulse: an unexpected packet finished discarding.

## Operation

States: IDLE, DATA, DRAIN, REPORT.

IDLE
- `rsp_ready_o = 1`.
- A header beat is accepted: capture addr, size and error; clear the byte counter.
- Beats with `first = 0` in IDLE are discarded silently.
- Header handling, in priority order:
  - `!read_wait_i`: go to DRAIN and flag drop. If `last` is set on the header, go straight to IDLE and pulse `drop_o` next cycle.
  - `rsp_error_i != ERR_NONE`: latch that error; size = 0. Go to REPORT if `last`, else DRAIN.
  - `addr[log2(DATA_B)-1:0] != 0`: latch `ERR_UNALIGNED`. Go to REPORT if `last`, else DRAIN.
  - `size == 0` or `last`: go to REPORT with size 0.
  - Otherwise: go to DATA.

DATA
- `rsp_ready_o = !mem_stall_i`.
- `mem_en_o = rsp_valid_i`.
- `mem_addr_o = addr + written`.
- `mem_wben_o`: all ones if `remaining ≥ DATA_B`, else the low `remaining` bits set.
- On accept: `written += min(remaining, DATA_B)`.
- A packet that is too short ends at REPORT with `size = written` on the beat with `last`. The request FSM keeps waiting for the rest.
- When `remaining` reaches 0 without `last`, go to DRAIN. The report is still due.

DRAIN
- `ready = 1`, `mem_en_o = 0`. Beats are consumed until `last`.
- Then go to REPORT, or to IDLE with a `drop_o` pulse for an unexpected packet.

REPORT
- `ready = 0`.
- `noc_rsp_recv_o = 1` with the latched error and `written`.
- Next state IDLE.

Arithmetic
- `remaining = size - written`, 32-bit unsigned.
- Address add is 32-bit and wraps modulo 2^32; no error on wrap.

Reset
- Synchronous. Mid-packet reset returns to IDLE; any remaining beats of that packet are then discarded as non-header beats.
- Reset values: `rsp_ready_o = 1`, `mem_en_o = 0`, `mem_wben_o = 0`, `mem_addr_o = 0`, `noc_rsp_recv_o = 0`, `noc_rsp_error_o = ERR_NONE`, `noc_rsp_size_o = 0`, `drop_o = 0`.

## Timing

- Header costs one accept cycle. Writes are combinational pass-through on the accept cycle: 0-cycle beat-to-write latency.
- `noc_rsp_recv_o` asserts exactly 1 cycle after the accept of the final beat. With a header-only packet it asserts 1 cycle after the header.
- `mem_stall_i` holds `ready` low. `mem_en_o` and `addr`/`wben`/`wdata` stay stable while `rsp_valid_i` holds.
- Back-to-back packets: a header can be accepted the cycle after REPORT (the IDLE cycle). Minimum packet spacing is 1 idle cycle.
- `read_wait_i` is only sampled at the header. Deassertion mid-packet has no effect.

## Test plan

- Addr 0x1000, size 20, `DATA_B` = 8, 3 data beats → writes:
  - 0x1000 with wben 0xFF;
  - 0x1008 with wben 0xFF;
  - 0x1010 with wben 0x0F;
  - then `recv` with size 20, error 0 one cycle later.
- Same packet with `mem_stall_i` high for 3 cycles on beat 2 → `ready` low 3 cycles, no duplicate write, same final report.
- Header with `rsp_error_i = 5'h3` plus 2 trailing beats → no `mem_en_o`; `recv` with error 3, size 0 after the 2nd beat.
- Header addr 0x1004 → `ERR_UNALIGNED`, size 0, no writes.
- Header with `read_wait_i = 0`, size 16, 2 beats → no writes, no `recv`, `drop_o` pulse; the next valid packet completes normally.
- Size 8 but 3 data beats → 1 write (0xFF), 2 beats drained, `recv` with size 8. Reset asserted mid-DATA → next cycle IDLE, all outputs at reset values.
